// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared byte-width definitions for the CPU datapath blocks.
// Contents : BYTE_W - width of a datapath byte
//            byte_t - one datapath byte
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int BYTE_W = 8;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : byte_fifo
// Purpose  : Small synchronous byte FIFO with an occupancy count. The head
//            entry is read combinationally from registered storage.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            push, din      - write din when not full
//            pop            - drop the head entry when not empty
//            dout           - head entry (last popped head while empty)
//            empty, full    - occupancy flags
//            level          - entry count, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module byte_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  byte_t       din,
  output byte_t       dout,
  output logic        empty,
  output logic        full,
  output logic [AW:0] level
);

  localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

  byte_t         r_mem [DEPTH];
  byte_t         r_last;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == c_full);
  assign level  = r_count;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  // While empty the storage slot under the read pointer is stale or unused,
  // so the previously popped head is presented instead to keep dout steady.
  assign dout = empty ? r_last : r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;  // wraps modulo DEPTH (power of 2)
      end
      if (w_pop) begin
        r_last <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : byte_fifo
`default_nettype wire

// File: rtl/byte_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : byte_demux_1to2
// Purpose  : Steers a single byte stream to one of two sinks, chosen per byte
//            by in_sel (0 -> dest 1, 1 -> dest 2). Each sink has its own FIFO
//            so a stalled sink never blocks traffic to the other.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            in_valid/in_ready/in_data    - producer handshake and byte
//            in_sel                       - destination select
//            outN_valid/outN_ready        - dest-N consumer handshake
//            outN_data                    - dest-N head byte
//            outN_level                   - dest-N occupancy, 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module byte_demux_1to2
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sel,
  output logic        out1_valid,
  input  logic        out1_ready,
  output logic [7:0]  out1_data,
  output logic [AW:0] out1_level,
  output logic        out2_valid,
  input  logic        out2_ready,
  output logic [7:0]  out2_data,
  output logic [AW:0] out2_level
);

  logic w_empty1, w_full1, w_push1, w_pop1;
  logic w_empty2, w_full2, w_push2, w_pop2;

  // Ready depends only on registered fullness and the select, never on the
  // sink-side ready, so no combinational path crosses the block.
  assign in_ready = in_sel ? ~w_full2 : ~w_full1;

  assign w_push1 = in_valid & in_ready & ~in_sel;
  assign w_push2 = in_valid & in_ready &  in_sel;

  assign out1_valid = ~w_empty1;
  assign out2_valid = ~w_empty2;
  assign w_pop1     = out1_valid & out1_ready;
  assign w_pop2     = out2_valid & out2_ready;

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push1),
    .pop   (w_pop1),
    .din   (in_data),
    .dout  (out1_data),
    .empty (w_empty1),
    .full  (w_full1),
    .level (out1_level)
  );

  byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo2 (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push2),
    .pop   (w_pop2),
    .din   (in_data),
    .dout  (out2_data),
    .empty (w_empty2),
    .full  (w_full2),
    .level (out2_level)
  );

endmodule : byte_demux_1to2
`default_nettype wire

// File: tb/tb_byte_demux_1to2.sv
`default_nettype none
// ============================================================================
// Module   : tb_byte_demux_1to2
// Purpose  : Directed self-checking bench for byte_demux_1to2 with a
//            per-destination scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byte_demux_1to2;

  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sel;
  logic        out1_valid;
  logic        out1_ready;
  logic [7:0]  out1_data;
  logic [AW:0] out1_level;
  logic        out2_valid;
  logic        out2_ready;
  logic [7:0]  out2_data;
  logic [AW:0] out2_level;

  int tests = 0;
  int fails = 0;
  int pop2_cnt = 0;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  always #5 clk = ~clk;

  byte_demux_1to2 #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_level (out1_level),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out2_data  (out2_data),
    .out2_level (out2_level)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Post-edge check of both outputs against the scoreboard.
  task automatic chk_state();
    chk("lvl1", 9'(out1_level), 9'(q1.size()));
    chk("lvl2", 9'(out2_level), 9'(q2.size()));
    chk("vld1", 9'(out1_valid), 9'(q1.size() != 0));
    chk("vld2", 9'(out2_valid), 9'(q2.size() != 0));
    if (q1.size() != 0) chk("head1", 9'(out1_data), 9'(q1[0]));
    if (q2.size() != 0) chk("head2", 9'(out2_data), 9'(q2[0]));
  endtask

  // One clock cycle: drive, check ready, score pops/pushes, clock, check.
  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic r1, input logic r2, output logic acc);
    logic exp_rdy;
    logic [7:0] e;
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out1_ready = r1;
    out2_ready = r2;
    #1;
    exp_rdy = s ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
    chk("in_ready", 9'(in_ready), 9'(exp_rdy));
    if (r1 && q1.size() != 0) begin
      e = q1.pop_front();
      chk("pop1", 9'(out1_data), 9'(e));
    end
    if (r2 && q2.size() != 0) begin
      e = q2.pop_front();
      chk("pop2", 9'(out2_data), 9'(e));
      pop2_cnt++;
    end
    acc = v && exp_rdy;
    if (acc) begin
      if (s) q2.push_back(d);
      else   q1.push_back(d);
    end
    @(posedge clk);
    #1;
    chk_state();
  endtask

  task automatic do_reset(input int n);
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'b0;
    in_data    = 8'hFF;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    q1.delete();
    q2.delete();
    chk_state();
    chk("rst_data1", 9'(out1_data), 9'h000);
    chk("rst_data2", 9'(out2_data), 9'h000);
    in_valid = 1'b0;
    #1;
    chk("rst_ready", 9'(in_ready), 9'h001);
  endtask

  initial begin
    logic acc;
    int   i;
    int   guard;

    // 1: reset with in_valid held high
    do_reset(2);

    // 2: routing to each destination
    step(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, acc);
    chk("route1", 9'(out1_data), 9'h0A5);
    step(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0, acc);
    chk("route2", 9'(out2_data), 9'h03C);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);

    // 3: backpressure on dest 1, dest 2 still flows
    step(1'b1, 1'b0, 8'h01, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 8'h02, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 8'h03, 1'b0, 1'b0, acc);
    chk("bp_rejected", 9'(acc), 9'h000);
    chk("bp_level", 9'(out1_level), 9'h002);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, acc);
    chk("bp_dest2", 9'(out2_data), 9'h077);
    chk("bp_level_hold", 9'(out1_level), 9'h002);

    // 4: simultaneous push/pop on dest 1 holding one entry
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    chk("pp_pre", 9'(out1_level), 9'h001);
    step(1'b1, 1'b0, 8'h11, 1'b1, 1'b0, acc);
    chk("pp_level", 9'(out1_level), 9'h001);
    chk("pp_head", 9'(out1_data), 9'h011);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, acc);  // pop on empty: no effect

    // 5: wrap-around stream to dest 2 with toggling ready
    pop2_cnt = 0;
    i = 0;
    guard = 0;
    while (i < 16 && guard < 200) begin
      step(1'b1, 1'b1, 8'(i), 1'b0, 1'(guard % 3 != 0), acc);
      if (acc) i++;
      guard++;
    end
    chk("wrap_sent", 9'(i), 9'd16);
    guard = 0;
    while (q2.size() != 0 && guard < 20) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, acc);
      guard++;
    end
    chk("wrap_popped", 9'(pop2_cnt), 9'd16);

    // 6: reset with both FIFOs full
    step(1'b1, 1'b0, 8'hC1, 1'b0, 1'b0, acc);
    step(1'b1, 1'b0, 8'hC2, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 8'hD1, 1'b0, 1'b0, acc);
    step(1'b1, 1'b1, 8'hD2, 1'b0, 1'b0, acc);
    chk("full_lvl1", 9'(out1_level), 9'h002);
    chk("full_lvl2", 9'(out2_level), 9'h002);
    do_reset(1);
    step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, acc);
    chk("post_rst_head", 9'(out1_data), 9'h0EE);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_byte_demux_1to2
`default_nettype wire
